// File: rtl/uart_receiver_fsm.sv
// UART receive FSM: 2-flop input synchronizer, mid-bit start validation,
// centre sampling of data/parity/stop, registered parallel output with
// a one-cycle valid strobe and parity/framing error flags.
module uart_receiver_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 Baud_Clk,
    input  logic                 Reset,
    input  logic                 Rx_in,
    output logic [DATA_BITS-1:0] Rx_data,
    output logic                 Rx_valid,
    output logic                 Parity_err,
    output logic                 Frame_err,
    output logic                 Rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BIT   = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [DATA_BITS-1:0] sh;
    logic [DATA_BITS-1:0] sh_nxt;
    logic                 par;
    logic                 par_nxt;
    logic                 frame_done;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge Baud_Clk) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx_in;
            rx_s    <= rx_meta;
        end
    end

    // State register and per-frame working registers.
    always_ff @(posedge Baud_Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            sh    <= sh_nxt;
            par   <= par_nxt;
        end
    end

    // Next-state and working-register update; frame_done flags the stop-bit sample.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        sh_nxt     = sh;
        par_nxt    = par;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START_BIT;
                    cnt_nxt   = '0;
                end
            end
            START_BIT: begin
                if (cnt == HALF_LAST) begin
                    if (!rx_s) begin
                        state_nxt = DATA_BIT;
                        cnt_nxt   = '0;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA_BIT: begin
                if (cnt == BIT_LAST) begin
                    sh_nxt  = {rx_s, sh[DATA_BITS-1:1]};
                    cnt_nxt = '0;
                    if (idx == IDX_LAST) begin
                        if (PARITY_EN) begin
                            state_nxt = PARITY_BIT;
                        end else begin
                            state_nxt = STOP_BIT;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PARITY_BIT: begin
                if (cnt == BIT_LAST) begin
                    par_nxt   = rx_s;
                    cnt_nxt   = '0;
                    state_nxt = STOP_BIT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP_BIT: begin
                if (cnt == BIT_LAST) begin
                    frame_done = 1'b1;
                    cnt_nxt    = '0;
                    if (rx_s) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BREAK_WAIT;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BREAK_WAIT: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output registers: updated only when a frame completes, strobe lasts one cycle.
    always_ff @(posedge Baud_Clk) begin
        if (Reset) begin
            Rx_data    <= '0;
            Rx_valid   <= 1'b0;
            Parity_err <= 1'b0;
            Frame_err  <= 1'b0;
        end else begin
            Rx_valid <= frame_done;
            if (frame_done) begin
                Rx_data    <= sh;
                Parity_err <= PARITY_EN & (^sh ^ par ^ PARITY_ODD);
                Frame_err  <= ~rx_s;
            end
        end
    end

    assign Rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Self-checking bench for uart_receiver_fsm at default parameters
// (8 data bits, 16x oversample, even parity).
module tb_uart_receiver_fsm;

    logic       Baud_Clk = 1'b0;
    logic       Reset;
    logic       Rx_in;
    logic [7:0] Rx_data;
    logic       Rx_valid;
    logic       Parity_err;
    logic       Frame_err;
    logic       Rx_busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    // Expected completed frame, derived from what was put on the line.
    typedef struct {
        logic [7:0]  d;
        bit          pe;
        bit          fe;
        int unsigned at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    uart_receiver_fsm #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut (
        .Baud_Clk  (Baud_Clk),
        .Reset     (Reset),
        .Rx_in     (Rx_in),
        .Rx_data   (Rx_data),
        .Rx_valid  (Rx_valid),
        .Parity_err(Parity_err),
        .Frame_err (Frame_err),
        .Rx_busy   (Rx_busy)
    );

    always #5 Baud_Clk = ~Baud_Clk;

    always @(posedge Baud_Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Even-parity bit that makes the total count of ones even.
    function automatic bit even_bit(input logic [7:0] d);
        return bit'($countones(d) % 2);
    endfunction

    task automatic send_bit(input logic b, input int unsigned n);
        Rx_in = b;
        repeat (n) begin
            @(posedge Baud_Clk);
            #1;
        end
    endtask

    // Line falls in the current cycle; the synchronizer adds 2, and the
    // valid strobe lands 169 cycles after the first synchronized low.
    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop,
                              input int unsigned extra_low, input int unsigned gap);
        exp_t e;
        e.d  = d;
        e.pe = (($countones(d) + int'(pbit)) % 2) == 1;
        e.fe = !stop;
        e.at = cyc + 171;
        exp_q.push_back(e);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(pbit, 16);
        send_bit(stop, 16);
        if (extra_low > 0) send_bit(1'b0, extra_low);
        if (gap > 0) send_bit(1'b1, gap);
    endtask

    // Every strobe must match the next expected frame in content and timing.
    always @(negedge Baud_Clk) begin
        if (Rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(Rx_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rx_data", 32'(Rx_data), 32'(mon_e.d));
                check("parity_err", 32'(Parity_err), 32'(mon_e.pe));
                check("frame_err", 32'(Frame_err), 32'(mon_e.fe));
                check("valid_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  d;
        bit          pb;
        bit          st;
        int unsigned xl;
        int unsigned gp;
        int unsigned waited;

        Reset = 1'b1;
        Rx_in = 1'b1;
        repeat (3) @(posedge Baud_Clk);
        #1;
        check("rst_data", 32'(Rx_data), 32'd0);
        check("rst_valid", 32'(Rx_valid), 32'd0);
        check("rst_perr", 32'(Parity_err), 32'd0);
        check("rst_ferr", 32'(Frame_err), 32'd0);
        check("rst_busy", 32'(Rx_busy), 32'd0);
        Reset = 1'b0;
        send_bit(1'b1, 10);

        // Clean frame, then a parity error, then a clean frame that clears it.
        send_frame(8'hA5, 1'b0, 1'b1, 0, 10);
        send_frame(8'h3C, 1'b1, 1'b1, 0, 10);
        send_frame(8'h00, 1'b0, 1'b1, 0, 10);

        // Back-to-back frames with no idle gap.
        send_frame(8'h12, even_bit(8'h12), 1'b1, 0, 0);
        send_frame(8'h34, even_bit(8'h34), 1'b1, 0, 20);

        // Short glitch: false start, no strobe, outputs held.
        send_bit(1'b0, 4);
        check("glitch_busy_hi", 32'(Rx_busy), 32'd1);
        send_bit(1'b1, 20);
        check("glitch_busy_lo", 32'(Rx_busy), 32'd0);
        check("glitch_data", 32'(Rx_data), 32'h34);
        check("glitch_perr", 32'(Parity_err), 32'd0);
        check("glitch_ferr", 32'(Frame_err), 32'd0);

        // Stop bit held low for 40 ticks: framing error, then break wait.
        send_frame(8'h55, even_bit(8'h55), 1'b0, 24, 0);
        check("break_busy", 32'(Rx_busy), 32'd1);
        send_bit(1'b1, 20);
        check("break_idle", 32'(Rx_busy), 32'd0);
        send_frame(8'h81, even_bit(8'h81), 1'b1, 0, 20);

        // Reset in the middle of data bit 3.
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 8);
        check("midrst_busy_pre", 32'(Rx_busy), 32'd1);
        Reset = 1'b1;
        Rx_in = 1'b1;
        @(posedge Baud_Clk);
        #1;
        check("midrst_data", 32'(Rx_data), 32'd0);
        check("midrst_valid", 32'(Rx_valid), 32'd0);
        check("midrst_perr", 32'(Parity_err), 32'd0);
        check("midrst_ferr", 32'(Frame_err), 32'd0);
        check("midrst_busy", 32'(Rx_busy), 32'd0);
        Reset = 1'b0;
        send_bit(1'b1, 20);
        send_frame(8'hF0, even_bit(8'hF0), 1'b1, 0, 15);

        // Randomized frames with occasional parity and framing errors.
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            pb = even_bit(d) ^ ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 4) != 0);
            xl = st ? 0 : $urandom_range(0, 30);
            gp = st ? $urandom_range(0, 12) : $urandom_range(1, 12);
            send_frame(d, pb, st, xl, gp);
        end
        send_bit(1'b1, 20);

        waited = 0;
        while (exp_q.size() != 0 && waited < 400) begin
            @(posedge Baud_Clk);
            #1;
            waited++;
        end
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(Rx_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver_fsm.md
# uart_receiver_fsm

Serial receive side of the UART: recovers start/data/parity/stop frames from the line using the same 16x oversampled baud clock as the transmitter FSM. Validates the start bit at mid-bit, samples each later bit at its centre, checks parity and stop bit, and presents a parallel byte with a one-cycle valid strobe and error flags. Sits between the pad-side `Rx_in` line and the receive buffer / host logic.

## Interface
- `DATA_BITS`, 8, data bits per frame, sent LSB first (valid range 5–8).
- `OVERSAMPLE`, 16, `Baud_Clk` ticks per bit; must be even and at least 8.
- `PARITY_EN`, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- `PARITY_ODD`, 0, 0 = even parity; 1 = odd parity.
- `Baud_Clk`  in  1  The only clock; one cycle is one oversample tick.
- `Reset`  in  1  Synchronous, active-high reset, sampled on the rising edge of `Baud_Clk`.
- `Rx_in`  in  1  Asynchronous serial line; idle level is high.
- `Rx_data`  out  DATA_BITS  Last received data word.
- `Rx_valid`  out  1  One-cycle pulse when a frame completes.
- `Parity_err`  out  1  Parity mismatch on the last completed frame.
- `Frame_err`  out  1  Stop bit was sampled low on the last completed frame.
- `Rx_busy`  out  1  High while the FSM is not in IDLE.

## Operation
- `Rx_in` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- Internal registers:
  - tick counter `cnt`, width clog2(OVERSAMPLE);
  - bit index `idx`;
  - shift register `sh`, filled LSB first by right-shifting in `rx_s` at the MSB;
  - parity bit register `par`.
- States, 3-bit encoding: IDLE=0, START_BIT=1, DATA_BIT=2, PARITY_BIT=3, STOP_BIT=4, BREAK_WAIT=5. Unused codes go to IDLE.
- **IDLE:** if `rx_s`==0, go to START_BIT with `cnt`=0.
- **START_BIT:** `cnt` increments each tick. At `cnt`==OVERSAMPLE/2-1:
  - `rx_s`==0 → go to DATA_BIT, `cnt`=0, `idx`=0;
  - `rx_s`==1 → false start; return to IDLE with no output change.
- **DATA_BIT:** `cnt` increments each tick. At `cnt`==OVERSAMPLE-1: shift `rx_s` into `sh` and set `cnt`=0.
  - If `idx`==DATA_BITS-1, go to PARITY_BIT (PARITY_EN=1) or STOP_BIT (PARITY_EN=0).
  - Otherwise `idx`++.
- **PARITY_BIT:** at `cnt`==OVERSAMPLE-1, capture `rx_s` into `par`, set `cnt`=0, go to STOP_BIT.
- **STOP_BIT:** at `cnt`==OVERSAMPLE-1, on the next edge:
  - `Rx_data`←`sh`;
  - `Parity_err`←PARITY_EN & (^`sh` ^ `par` ^ PARITY_ODD);
  - `Frame_err`←~`rx_s`;
  - `Rx_valid`←1 for exactly one cycle.
  - Then go to IDLE if `rx_s`==1, or to BREAK_WAIT if `rx_s`==0.
- **BREAK_WAIT:** stay until `rx_s`==1, then go to IDLE. This prevents a held-low line from starting a new frame.
- `Rx_valid` pulses on every completed frame, including frames with errors.
- `Rx_data`, `Parity_err` and `Frame_err` hold until the next frame completes.
- `Rx_busy` = (state != IDLE). It is combinational from the state register.

## Timing
- Reset values:
  - state IDLE; `cnt`, `idx`, `sh`, `par` all 0;
  - `Rx_data`=0, `Rx_valid`=0, `Parity_err`=0, `Frame_err`=0, `Rx_busy`=0.
- Let t be the first cycle where `rx_s`==0 in IDLE. This is 2 cycles after `Rx_in` falls.
  - Start bit is checked at t+OVERSAMPLE/2 (t+8 at default).
  - Data bit i is sampled at t+8+16(i+1).
  - Parity is sampled at t+152; stop at t+168 (t+152 with PARITY_EN=0).
  - `Rx_valid` is high in cycle t+169 (t+153 with PARITY_EN=0).
- Back-to-back frames: a new start edge is accepted in the cycle after the STOP→IDLE transition. There is no dead time beyond the stop bit.
- `Reset` mid-frame: the frame is abandoned, no `Rx_valid` is produced, and all outputs return to their reset values on the next edge.
- `Rx_in` glitches shorter than OVERSAMPLE/2 ticks produce a false start: return to IDLE, no `Rx_valid`, flags unchanged.

## Test plan
- Frame 0xA5 with even parity bit 0 and stop bit 1, default parameters → `Rx_valid` pulses once at t+169; `Rx_data`=0xA5, `Parity_err`=0, `Frame_err`=0.
- Frame 0x3C with parity bit 1 under even parity → `Rx_data`=0x3C, `Parity_err`=1. A following correct frame of 0x00 clears it to 0.
- Frame 0x55 with stop bit held low for 40 ticks, then high → `Frame_err`=1 and `Rx_valid` pulses. FSM sits in BREAK_WAIT with `Rx_busy`=1, then returns to IDLE; the next frame of 0x81 is received with `Frame_err`=0.
- `Rx_in` low for 4 ticks, then high → no `Rx_valid`; `Rx_busy` returns to 0 by t+8; `Rx_data` is unchanged.
- `Reset`=1 during data bit 3 of a frame → all outputs 0 on the next edge, no `Rx_valid`. The next full frame of 0xF0 decodes correctly.
- Two frames 0x12 and 0x34 back to back with no idle gap → two `Rx_valid` pulses 176 ticks apart, data 0x12 then 0x34, no errors.
